golomb_bit_packer: RTL
======================

# golomb_bit_packer

Downstream stage of the k-parameter calculation in the JPEG-LS encoder datapath. Takes one (k, MErrval) pair per handshake, forms the JPEG-LS limited-length Golomb-Rice codeword, and serializes it MSB-first into bytes. Applies JPEG-LS marker bit-stuffing: after any 0xFF byte, the next byte carries a forced 0 MSB. Streams bytes to the output writer over a valid/ready handshake and zero-pads to a byte boundary on flush.

## Interface

Parameters:

- `k_length`, 4, width of k
- `MErrval_length`, 9, width of the mapped error value
- `LIMIT`, 32, maximum codeword length in bits
- `qbpp`, 8, bits per escaped sample

Ports:

- `clk`, input, 1, single clock; all state updates on the rising edge
- `rst`, input, 1, reset, synchronous and active-high
- `in_valid`, input, 1, k and MErrval valid
- `in_ready`, output, 1, high exactly when state = IDLE
- `k`, input, `k_length`, Golomb parameter from the k-calculation stage
- `MErrval`, input, `MErrval_length`, mapped error value
- `flush`, input, 1, level request to pad and drain; acted on only in IDLE with in_valid low
- `out_valid`, output, 1, out_byte holds a completed byte
- `out_ready`, input, 1, consumer accepts out_byte
- `out_byte`, output, 8, packed byte, first-coded bit in bit 7
- `flush_done`, output, 1, one-cycle pulse when the flush has fully drained

## Operation

- **States:**
  - IDLE: accept a codeword, or start a flush.
  - UNARY: emit zeros.
  - ONE: emit the single 1.
  - BINARY: emit the binary suffix.
  - FLUSH: pad and wait for the drain, then return to IDLE.
- **Acceptance:** a codeword is captured when in_valid && in_ready. At that point latch k and MErrval and compute q = MErrval >> k.
- **Regular codeword** (q < LIMIT−qbpp−1 = 23):
  - q zeros, then 1, then the low k bits of MErrval MSB-first.
  - Length q+1+k. If k = 0, BINARY is skipped.
  - Bits of MErrval above its width read as 0.
- **Escape codeword** (q ≥ 23):
  - 23 zeros, then 1, then (MErrval−1) in qbpp bits.
  - Length always 32 (LIMIT).
- **State entry from IDLE:** UNARY if the zero count > 0, else ONE.
- **Emission rate:** one bit per non-stalled cycle. After the last bit, return to IDLE.
- **Byte assembler:**
  - Holds a shift register and a bit count `cnt`.
  - Capacity is 8, or 7 when the previously completed byte was 0xFF. In that case bit 7 is forced 0 and the data bits fill bits 6..0.
  - When a bit fills the capacity, the byte moves to the output register, out_valid is set, `cnt` is cleared, and the stuff flag is updated from this byte.
- **Stall:** a bit that would complete a byte while out_valid && !out_ready is not consumed. State, counters and the assembler all hold. Bits that do not complete a byte are never stalled.
- **Output register:** out_valid clears on out_ready unless a new byte loads in the same cycle. A completing bit may load simultaneously with the previous byte being accepted.
- **Flush** (IDLE, flush high, in_valid low):
  - If cnt > 0, pad with zeros to capacity and emit the byte.
  - Then wait until out_valid is 0, pulse flush_done, and return to IDLE.
  - If cnt = 0 and the stuff flag is set, emit 0x00.
  - The stuff flag clears after a flush.
- **Simultaneous requests:** in_valid and flush both high in IDLE → the codeword wins, and flush is ignored that cycle.
- **Reset values:**
  - out_valid = 0, out_byte = 0x00, flush_done = 0, in_ready = 1.
  - cnt = 0, stuff flag = 0, state = IDLE.
  - A reset mid-codeword or mid-flush discards all partial bits and any pending byte.

## Timing

- An L-bit codeword with no stall occupies L cycles after the acceptance edge. in_ready rises on the cycle after the last bit, so there is one codeword per L+1 cycles.
- out_valid rises the cycle after the completing bit's edge.
- out_byte is stable while out_valid && !out_ready.
- flush_done asserts the cycle after the final padded byte is accepted. If there is nothing to emit, it asserts one cycle after flush is seen.
- No combinational path from in_valid or out_ready to any output except through registered state. in_ready is decoded from the state register.

## Test plan

1. **Two regular codewords, then flush.** k=2, MErrval=5 → bits 0101; k=0, MErrval=3 → bits 0001; then flush.
   - Exactly one byte, 0x51.
   - flush_done pulses once with no padding byte.
2. **Escape codeword.** k=0, MErrval=100, then flush.
   - Bytes 0x00, 0x00, 0x01, 0x63.
   - in_ready is low for exactly 32 cycles.
3. **Bit-stuffing.** k=7, MErrval=127; then k=0, MErrval=0; then flush.
   - Bytes 0xFF, then 0x40 (7-bit capacity, MSB 0).
4. **Backpressure.** Repeat scenario 2 with out_ready low for 10 cycles after the first out_valid.
   - out_byte stays 0x00 and stable while out_ready is low.
   - The byte sequence is identical to scenario 2 and no bit is lost.
5. **Reset mid-codeword.** Assert rst during BINARY of k=4, MErrval=200.
   - Next cycle: out_valid=0, in_ready=1.
   - Then k=2, MErrval=5 followed by flush yields exactly 0x50.
6. **Throughput.** k=1, MErrval=2 (bits 010) with in_valid held high for 8 codewords and out_ready=1.
   - in_ready pulses every 4 cycles.
   - Three bytes 0x49, 0x24, 0x92 are emitted.

Source files
------------

// File: rtl/golomb_bit_packer.sv
// JPEG-LS limited-length Golomb-Rice encoder back end: builds each codeword bit by bit
// and packs it MSB-first into bytes with 0xFF marker stuffing and flush-to-byte padding.
module golomb_bit_packer #(
  parameter int k_length       = 4,
  parameter int MErrval_length = 9,
  parameter int LIMIT          = 32,
  parameter int qbpp           = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [k_length-1:0]       k,
  input  logic [MErrval_length-1:0] MErrval,
  input  logic                      flush,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [7:0]                out_byte,
  output logic                      flush_done
);

  localparam int QMAX  = LIMIT - qbpp - 1;
  localparam int KMAX  = (1 << k_length) - 1;
  localparam int SUF_W = (KMAX > qbpp) ? KMAX : qbpp;
  localparam int SC_W  = $clog2(SUF_W + 1);
  localparam int Z_W   = $clog2(QMAX + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_UNARY,
    S_ONE,
    S_BINARY,
    S_FLUSH
  } state_t;

  state_t             r_state;
  logic [Z_W-1:0]     r_zeros;
  logic [SUF_W-1:0]   r_bin;
  logic [SC_W-1:0]    r_bin_cnt;
  logic [7:0]         r_shift;
  logic [3:0]         r_cnt;
  logic               r_stuff;
  logic               r_out_valid;
  logic [7:0]         r_out_byte;
  logic               r_flush_done;

  logic [MErrval_length-1:0] w_q;
  logic                      w_escape;
  logic [Z_W-1:0]            w_zeros;
  logic [SUF_W-1:0]          w_mask;
  logic [SUF_W-1:0]          w_bin;
  logic [SC_W-1:0]           w_bin_cnt;
  logic                      w_bit;
  logic [3:0]                w_cap;
  logic                      w_full;
  logic                      w_out_free;
  logic                      w_emitting;
  logic                      w_advance;
  logic                      w_pending;
  logic [7:0]                w_byte_new;
  logic [7:0]                w_pad_byte;

  // Escape codes replace the unary prefix with a fixed QMAX zeros and send MErrval-1 raw.
  assign w_q       = MErrval >> k;
  assign w_escape  = (w_q >= MErrval_length'(QMAX));
  assign w_zeros   = w_escape ? Z_W'(QMAX) : w_q[Z_W-1:0];
  assign w_mask    = (SUF_W'(1) << k) - SUF_W'(1);
  assign w_bin     = w_escape ? SUF_W'(MErrval[qbpp-1:0] - qbpp'(1))
                              : (SUF_W'(MErrval) & w_mask);
  assign w_bin_cnt = w_escape ? SC_W'(qbpp) : SC_W'(k);

  always_comb begin
    w_bit = 1'b0;
    case (r_state)
      S_ONE:    w_bit = 1'b1;
      S_BINARY: w_bit = r_bin[r_bin_cnt - SC_W'(1)];
      default:  w_bit = 1'b0;
    endcase
  end

  // After a 0xFF byte only 7 data bits fit; bit 7 stays 0 because the shifter starts cleared.
  assign w_cap      = r_stuff ? 4'd7 : 4'd8;
  assign w_full     = ((r_cnt + 4'd1) == w_cap);
  assign w_out_free = !r_out_valid || out_ready;
  assign w_emitting = (r_state == S_UNARY) || (r_state == S_ONE) || (r_state == S_BINARY);
  assign w_advance  = w_emitting && (!w_full || w_out_free);
  assign w_pending  = (r_cnt != 4'd0) || r_stuff;
  assign w_byte_new = {r_shift[6:0], w_bit};
  assign w_pad_byte = r_shift << (w_cap - r_cnt);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_zeros      <= '0;
      r_bin        <= '0;
      r_bin_cnt    <= '0;
      r_shift      <= '0;
      r_cnt        <= '0;
      r_stuff      <= 1'b0;
      r_out_valid  <= 1'b0;
      r_out_byte   <= '0;
      r_flush_done <= 1'b0;
    end else begin
      r_flush_done <= 1'b0;
      if (r_out_valid && out_ready) begin
        r_out_valid <= 1'b0;
      end

      if (w_advance) begin
        if (w_full) begin
          r_out_byte  <= w_byte_new;
          r_out_valid <= 1'b1;
          r_shift     <= '0;
          r_cnt       <= '0;
          r_stuff     <= (w_byte_new == 8'hFF);
        end else begin
          r_shift <= w_byte_new;
          r_cnt   <= r_cnt + 4'd1;
        end
      end

      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_zeros   <= w_zeros;
            r_bin     <= w_bin;
            r_bin_cnt <= w_bin_cnt;
            r_state   <= (w_zeros != '0) ? S_UNARY : S_ONE;
          end else if (flush) begin
            if (!w_pending && w_out_free) begin
              r_flush_done <= 1'b1;
            end else begin
              r_state <= S_FLUSH;
            end
          end
        end
        S_UNARY: begin
          if (w_advance) begin
            r_zeros <= r_zeros - Z_W'(1);
            if (r_zeros == Z_W'(1)) begin
              r_state <= S_ONE;
            end
          end
        end
        S_ONE: begin
          if (w_advance) begin
            r_state <= (r_bin_cnt == '0) ? S_IDLE : S_BINARY;
          end
        end
        S_BINARY: begin
          if (w_advance) begin
            r_bin_cnt <= r_bin_cnt - SC_W'(1);
            if (r_bin_cnt == SC_W'(1)) begin
              r_state <= S_IDLE;
            end
          end
        end
        S_FLUSH: begin
          if (w_pending) begin
            if (w_out_free) begin
              r_out_byte  <= w_pad_byte;
              r_out_valid <= 1'b1;
              r_shift     <= '0;
              r_cnt       <= '0;
              r_stuff     <= 1'b0;
            end
          end else if (w_out_free) begin
            r_flush_done <= 1'b1;
            r_state      <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign in_ready   = (r_state == S_IDLE);
  assign out_valid  = r_out_valid;
  assign out_byte   = r_out_byte;
  assign flush_done = r_flush_done;

endmodule
